addrc_round_ctrl: RTL and testbench

Parametrised round sequencer for the add-round-constant stage of the encoder datapath. It accepts a start request over a ready/start handshake and issues a one-cycle load strobe. It then drives a per-round enable plus round index for NUM_ROUNDS rounds, in forward or reverse order, and signals completion with a one-cycle done pulse. It sits between the top-level encoder controller and the round-constant ROM/XOR datapath.

---
 rtl/addrc_pkg.sv | 7 +
 rtl/addrc_round_cnt.sv | 26 ++
 rtl/addrc_round_ctrl.sv | 64 ++++++
 tb/tb_addrc_round_ctrl.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/addrc_pkg.sv
// addrc_pkg: shared state type, default round count and direction encodings for the round sequencer.
package addrc_pkg;
  typedef enum logic [1:0] {IDLE, LOAD, ROUND, DONE} addrc_state_e;
  localparam int ADDRC_NUM_ROUNDS = 24;
  localparam logic ADDRC_DIR_FWD = 1'b0;
  localparam logic ADDRC_DIR_REV = 1'b1;
endpackage

// File: rtl/addrc_round_cnt.sv
// addrc_round_cnt: round up/down counter with direction-dependent load value and terminal flag.
module addrc_round_cnt
  import addrc_pkg::*;
#(
  parameter int NUM_ROUNDS = ADDRC_NUM_ROUNDS,
  localparam int IDX_W = (NUM_ROUNDS > 1) ? $clog2(NUM_ROUNDS) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_clr,
  input  logic             i_load,
  input  logic             i_dir,
  input  logic             i_step,
  output logic [IDX_W-1:0] o_cnt,
  output logic             o_term
);
  localparam logic [IDX_W-1:0] LAST = IDX_W'(NUM_ROUNDS - 1);
  logic [IDX_W-1:0] r_cnt;
  always_ff @(posedge clk) begin
    if (!rst || i_clr) r_cnt <= '0;
    else if (i_load) r_cnt <= (i_dir == ADDRC_DIR_REV) ? LAST : '0;
    else if (i_step) r_cnt <= (i_dir == ADDRC_DIR_REV) ? r_cnt - 1'b1 : r_cnt + 1'b1;
  end
  assign o_cnt  = r_cnt;
  assign o_term = (i_dir == ADDRC_DIR_REV) ? (r_cnt == '0) : (r_cnt == LAST);
endmodule

// File: rtl/addrc_round_ctrl.sv
// addrc_round_ctrl: start/load/round/done sequencer for the add-round-constant stage.
// Optional abort input enabled by defining ADDRC_CTRL_ABORT_EN.
module addrc_round_ctrl
  import addrc_pkg::*;
#(
  parameter int NUM_ROUNDS = ADDRC_NUM_ROUNDS,
  localparam int IDX_W = (NUM_ROUNDS > 1) ? $clog2(NUM_ROUNDS) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             dir,
  input  logic             hold,
`ifdef ADDRC_CTRL_ABORT_EN
  input  logic             abort,
`endif
  output logic             ready,
  output logic             ld,
  output logic             en,
  output logic [IDX_W-1:0] round_idx,
  output logic             done
);
  addrc_state_e     r_state;
  addrc_state_e     w_nxt;
  logic             r_dir;
  logic             w_abort;
  logic             w_term;
  logic [IDX_W-1:0] w_cnt;
`ifdef ADDRC_CTRL_ABORT_EN
  assign w_abort = abort && (r_state == LOAD || r_state == ROUND);
`else
  assign w_abort = 1'b0;
`endif
  // terminal check precedes the step, so the counter never leaves 0..NUM_ROUNDS-1
  assign w_nxt = w_abort              ? IDLE :
                 (r_state == IDLE)    ? (start ? LOAD : IDLE) :
                 (r_state == LOAD)    ? ROUND :
                 (r_state == ROUND)   ? ((!hold && w_term) ? DONE : ROUND) :
                                        IDLE;
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= IDLE;
      r_dir   <= ADDRC_DIR_FWD;
    end else begin
      r_state <= w_nxt;
      if (r_state == IDLE && start) r_dir <= dir;
    end
  end
  addrc_round_cnt #(.NUM_ROUNDS(NUM_ROUNDS)) u_cnt (
    .clk    (clk),
    .rst    (rst),
    .i_clr  (w_abort),
    .i_load (r_state == LOAD),
    .i_dir  (r_dir),
    .i_step (r_state == ROUND && !hold && !w_term),
    .o_cnt  (w_cnt),
    .o_term (w_term)
  );
  assign ready     = (r_state == IDLE);
  assign ld        = (r_state == LOAD);
  assign en        = (r_state == ROUND) && !hold;
  assign round_idx = en ? w_cnt : '0;
  assign done      = (r_state == DONE);
endmodule

// File: tb/tb_addrc_round_ctrl.sv
// tb_addrc_round_ctrl: directed runs with a scoreboard of expected ld/en/done events and their cycles.
module tb_addrc_round_ctrl;
  localparam int N = 4;
  logic       clk = 0;
  logic       rst = 0;
  logic       start = 0;
  logic       dir = 0;
  logic       hold = 0;
`ifdef ADDRC_CTRL_ABORT_EN
  logic       abort = 0;
`endif
  logic       ready, ld, en, done;
  logic [1:0] round_idx;
  int         cyc = 0;
  int         tot = 0;
  int         bad = 0;
  typedef struct {int kind; int idx; int cyc;} ev_t;
  ev_t        q[$];

  addrc_round_ctrl #(.NUM_ROUNDS(N)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .dir       (dir),
    .hold      (hold),
`ifdef ADDRC_CTRL_ABORT_EN
    .abort     (abort),
`endif
    .ready     (ready),
    .ld        (ld),
    .en        (en),
    .round_idx (round_idx),
    .done      (done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // kind: 0 = ld, 1 = en, 2 = done
  always @(negedge clk) begin : monitor
    ev_t g, e;
    if (rst) begin
      if (!en) begin
        tot++;
        if (round_idx != 2'd0) begin
          bad++;
          $display("FAIL idle_idx got=%0d want=0 cyc=%0d", round_idx, cyc);
        end
      end
      if (ld || en || done) begin
        g.kind = done ? 2 : (en ? 1 : 0);
        g.idx  = int'(round_idx);
        g.cyc  = cyc;
        tot++;
        if ((int'(ld) + int'(en) + int'(done)) > 1) begin
          bad++;
          $display("FAIL overlap ld=%0b en=%0b done=%0b cyc=%0d", ld, en, done, cyc);
        end else if (q.size() == 0) begin
          bad++;
          $display("FAIL unexpected kind=%0d idx=%0d cyc=%0d", g.kind, g.idx, g.cyc);
        end else begin
          e = q.pop_front();
          if (g.kind != e.kind || g.idx != e.idx || g.cyc != e.cyc) begin
            bad++;
            $display("FAIL event got kind=%0d idx=%0d cyc=%0d want kind=%0d idx=%0d cyc=%0d",
                     g.kind, g.idx, g.cyc, e.kind, e.idx, e.cyc);
          end
        end
      end
    end
  end

  function automatic void push(input int k, input int i, input int c);
    ev_t e;
    e.kind = k;
    e.idx  = i;
    e.cyc  = c;
    q.push_back(e);
  endfunction

  task automatic check(input string name, input int got, input int exp);
    tot++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d cyc=%0d", name, got, exp, cyc);
    end
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!ready && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    check("wait_ready", int'(ready), 1);
  endtask

  // one run; hold for hl cycles starting at the hp-th round; noise toggles start/dir mid-run
  task automatic run(input bit d, input int hp, input int hl, input bit noise);
    int t;
    wait_ready();
    start = 1;
    dir   = d;
    t     = cyc + 1;
    push(0, 0, t);
    for (int k = 0; k < N; k++)
      push(1, d ? N - 1 - k : k, t + 1 + k + ((hl > 0 && k >= hp) ? hl : 0));
    push(2, 0, t + N + 1 + hl);
    @(posedge clk); #1;
    start = 0;
    while (cyc < t + N + 2 + hl) begin
      hold = (hl > 0) && (cyc >= t + 1 + hp) && (cyc < t + 1 + hp + hl);
      if (noise) begin
        start = 1'($urandom_range(0, 1));
        dir   = ~dir;
      end
      check("busy_ready", int'(ready), 0);
      @(posedge clk); #1;
    end
    hold  = 0;
    start = 0;
    check("ready_back", int'(ready), 1);
  endtask

  initial begin : stim
    int t;
    repeat (2) @(posedge clk);
    #1;
    check("rst_ready", int'(ready), 1);
    check("rst_ld", int'(ld), 0);
    check("rst_en", int'(en), 0);
    check("rst_idx", int'(round_idx), 0);
    check("rst_done", int'(done), 0);
    rst = 1;
    run(1'b0, 0, 0, 1'b0);
    run(1'b1, 0, 0, 1'b0);
    run(1'b0, 2, 2, 1'b0);
    run(1'b1, 1, 1, 1'b1);
    run(1'b0, 3, 1, 1'b1);
    // reset while round_idx==1
    wait_ready();
    start = 1;
    dir   = 0;
    t     = cyc + 1;
    push(0, 0, t);
    push(1, 0, t + 1);
    push(1, 1, t + 2);
    @(posedge clk); #1;
    start = 0;
    while (cyc < t + 2) begin
      @(posedge clk); #1;
    end
    @(negedge clk); #1;
    rst = 0;
    @(posedge clk); #1;
    rst = 1;
    check("midrst_ready", int'(ready), 1);
    check("midrst_en", int'(en), 0);
    check("midrst_idx", int'(round_idx), 0);
    repeat (N + 3) @(posedge clk);
    #1;
`ifdef ADDRC_CTRL_ABORT_EN
    wait_ready();
    start = 1;
    dir   = 0;
    t     = cyc + 1;
    push(0, 0, t);
    for (int k = 0; k < N; k++) push(1, k, t + 1 + k);
    @(posedge clk); #1;
    start = 0;
    while (cyc < t + N) begin
      @(posedge clk); #1;
    end
    abort = 1;
    @(posedge clk); #1;
    abort = 0;
    check("abort_ready", int'(ready), 1);
    repeat (N + 3) @(posedge clk);
    #1;
`endif
    run(1'b0, 0, 0, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    check("queue_empty", q.size(), 0);
    $display("test done: total=%0d bad=%0d", tot, bad);
    $finish;
  end
endmodule
